// File: rtl/conv_decoder_processing_element_if.sv
// Operand/result stream bundle for the decoder-side MAC processing element.
// The master is the sequencer feeding operand pairs and consuming results.
interface conv_decoder_processing_element_if;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] x;
  logic signed [17:0] w;
  logic signed [17:0] z;
  logic               sat;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output start, in_valid, x, w, out_ready,
    input  in_ready, z, sat, out_valid, busy
  );

  modport slave (
    input  start, in_valid, x, w, out_ready,
    output in_ready, z, sat, out_valid, busy
  );
endinterface

// File: rtl/conv_decoder_processing_element.sv
// Decoder-side MAC PE: accumulates TAPS signed 18x18 products, then rounds, shifts and
// saturates the sum back to an 18-bit activation held on a valid/ready output.
module conv_decoder_processing_element #(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 40
) (
  input logic                              clk,
  input logic                              rst_n,
  conv_decoder_processing_element_if.slave bus
);

  localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CntW-1:0] LastTap = CntW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] ZMax    = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] ZMin    = ACC_W'(-131072);
  localparam logic signed [ACC_W-1:0] RndBias = ACC_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StRnd, StOut} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CntW-1:0]   cnt_q, cnt_d;
  logic signed [17:0]       z_q, z_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [35:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  rnd_r;

  assign prod     = bus.x * bus.w;
  assign prod_ext = ACC_W'(prod);
  // Round half up, then arithmetic shift keeps the sign of negative sums.
  assign rnd_sum  = acc_q + RndBias;
  assign rnd_r    = rnd_sum >>> FRAC;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    z_d         = z_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StAcc: begin
        if (bus.in_valid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastTap) state_d = StRnd;
        end
      end
      StRnd: begin
        if (rnd_r > ZMax) begin
          z_d   = 18'sh1ffff;
          sat_d = 1'b1;
        end else if (rnd_r < ZMin) begin
          z_d   = 18'sh20000;
          sat_d = 1'b1;
        end else begin
          z_d   = rnd_r[17:0];
          sat_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          // A start coinciding with the accept chains straight into the next operation.
          if (bus.start) begin
            state_d = StAcc;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      z_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.busy      = (state_q != StIdle);
  assign bus.z         = z_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_decoder_processing_element.sv
// Self-checking bench for conv_decoder_processing_element: expected results are queued
// from a reference model as operands are driven and compared when out_valid appears.
module tb_conv_decoder_processing_element;

  localparam int TAPS = 9;
  localparam int FRAC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_decoder_processing_element_if bus ();

  conv_decoder_processing_element #(
    .TAPS (TAPS),
    .FRAC (FRAC),
    .ACC_W(40)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  longint      opx[$];
  longint      opw[$];
  logic [18:0] exp_q[$];
  logic [18:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fill(input longint xv, input longint wv);
    opx.delete();
    opw.delete();
    for (int i = 0; i < TAPS; i++) begin
      opx.push_back(xv);
      opw.push_back(wv);
    end
  endtask

  task automatic push_expected();
    longint acc = 0;
    longint r;
    logic [17:0] zz;
    logic ss;
    foreach (opx[i]) acc += opx[i] * opw[i];
    r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > 131071) begin
      zz = 18'h1ffff;
      ss = 1'b1;
    end else if (r < -131072) begin
      zz = 18'h20000;
      ss = 1'b1;
    end else begin
      zz = r[17:0];
      ss = 1'b0;
    end
    exp_q.push_back({ss, zz});
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.x = 18'(opx[i]);
      bus.w = 18'(opw[i]);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL in_ready_beat%0d got=%b want=1", i, bus.in_ready);
      end
      @(negedge clk);
      if (gap > 0 && i < n - 1) begin
        bus.in_valid = 1'b0;
        bus.x = 18'($urandom);
        bus.w = 18'($urandom);
        repeat (gap) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_out_valid_timeout got=%b want=1", name, bus.out_valid);
    end
    last_exp = exp_q.pop_front();
    checks++;
    if (bus.z !== last_exp[17:0] || bus.sat !== last_exp[18]) begin
      failures++;
      $display("FAIL %s_result got z=%0d sat=%b want z=%0d sat=%b", name, bus.z, bus.sat,
               $signed(last_exp[17:0]), last_exp[18]);
    end
  endtask

  task automatic accept(input logic with_start);
    bus.out_ready = 1'b1;
    bus.start = with_start;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== with_start || bus.in_ready !== with_start) begin
      failures++;
      $display("FAIL accept got out_valid=%b busy=%b in_ready=%b want 0/%b/%b", bus.out_valid,
               bus.busy, bus.in_ready, with_start, with_start);
    end
  endtask

  task automatic test_reset();
    int c;
    checks++;
    if (bus.z !== 18'd0 || bus.sat !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got z=%0d sat=%b ov=%b busy=%b ir=%b want all 0", bus.z,
               bus.sat, bus.out_valid, bus.busy, bus.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    fill(256, 256);
    do_start();
    drive_beats(TAPS, 0);
    push_expected();
    wait_result("pre_reset", c);
    accept(1'b0);
    // Abort mid-accumulation; z from the previous result must clear immediately.
    fill(1000, -77);
    do_start();
    drive_beats(4, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.z !== 18'd0 || bus.sat !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort got z=%0d sat=%b ov=%b busy=%b ir=%b want all 0", bus.z,
               bus.sat, bus.out_valid, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(3, -5);
    do_start();
    drive_beats(TAPS, 0);
    push_expected();
    wait_result("post_reset", c);
    accept(1'b0);
  endtask

  task automatic test_nominal();
    int c;
    fill(256, 256);
    do_start();
    drive_beats(TAPS, 0);
    push_expected();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_early_valid got=%b want=0", bus.out_valid);
    end
    wait_result("nominal", c);
    checks++;
    if (c != 1) begin
      failures++;
      $display("FAIL nominal_latency got=%0d want=1", c);
    end
    accept(1'b0);
  endtask

  task automatic test_rounding();
    int c;
    longint rx[3] = '{1, -1, -1};
    longint rw[3] = '{128, 128, 384};
    for (int k = 0; k < 3; k++) begin
      fill(0, 0);
      opx[0] = rx[k];
      opw[0] = rw[k];
      do_start();
      drive_beats(TAPS, 0);
      push_expected();
      wait_result($sformatf("round%0d", k), c);
      accept(1'b0);
    end
  endtask

  task automatic test_saturation();
    int c;
    fill(131071, 131071);
    do_start();
    drive_beats(TAPS, 0);
    push_expected();
    wait_result("sat_pos", c);
    accept(1'b0);
    fill(-131072, 131071);
    do_start();
    drive_beats(TAPS, 0);
    push_expected();
    wait_result("sat_neg", c);
    accept(1'b0);
  endtask

  task automatic test_gaps();
    int c;
    for (int g = 3; g >= 0; g -= 3) begin
      opx.delete();
      opw.delete();
      for (int i = 0; i < TAPS; i++) begin
        opx.push_back(i * 1000 - 3000);
        opw.push_back(500 - i * 77);
      end
      do_start();
      drive_beats(TAPS, g);
      push_expected();
      wait_result($sformatf("gap%0d", g), c);
      accept(1'b0);
    end
  endtask

  task automatic test_out_hold();
    int c;
    fill(1234, -321);
    opx[2] = -7777;
    do_start();
    drive_beats(TAPS, 0);
    push_expected();
    wait_result("hold_a", c);
    for (int k = 0; k < 5; k++) begin
      bus.start = k[0];
      bus.in_valid = 1'b1;
      bus.x = 18'($urandom);
      bus.w = 18'($urandom);
      @(negedge clk);
      checks++;
      if (bus.z !== last_exp[17:0] || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got z=%0d ov=%b ir=%b want z=%0d ov=1 ir=0", k, bus.z,
                 bus.out_valid, bus.in_ready, $signed(last_exp[17:0]));
      end
    end
    bus.in_valid = 1'b0;
    accept(1'b1);
    // Result of the chained op must reflect only its own beats (acc cleared).
    fill(-40, 99);
    drive_beats(TAPS, 0);
    push_expected();
    wait_result("hold_b", c);
    accept(1'b0);
  endtask

  task automatic test_back_to_back();
    int rise[3];
    bus.out_ready = 1'b1;
    do_start();
    for (int k = 0; k < 3; k++) begin
      opx.delete();
      opw.delete();
      for (int i = 0; i < TAPS; i++) begin
        opx.push_back((k + 1) * 900 - i * 311);
        opw.push_back(k * 1500 - 2000 + i * 53);
      end
      drive_beats(TAPS, 0);
      push_expected();
      bus.start = (k < 2);
      @(negedge clk);
      rise[k] = cyc;
      last_exp = exp_q.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.z !== last_exp[17:0] || bus.sat !== last_exp[18]) begin
        failures++;
        $display("FAIL b2b%0d got ov=%b z=%0d sat=%b want ov=1 z=%0d sat=%b", k, bus.out_valid,
                 bus.z, bus.sat, $signed(last_exp[17:0]), last_exp[18]);
      end
      @(negedge clk);
      bus.start = 1'b0;
      if (k > 0) begin
        checks++;
        if (rise[k] - rise[k-1] != TAPS + 2) begin
          failures++;
          $display("FAIL b2b_period%0d got=%0d want=%0d", k, rise[k] - rise[k-1], TAPS + 2);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got busy=%b ov=%b want 0/0", bus.busy, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.w = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_nominal();
    test_rounding();
    test_saturation();
    test_gaps();
    test_out_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
